// File: rtl/kernel_loader.sv
// Kernel weight loader: buffers a kernel from a beat stream, then replays it to
// the multicaster as one gap-free burst once the downstream buffer is free.
module kernel_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_KERNEL = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_valid,
    input  logic [7:0]            cfg_kernel_size,
    output logic                  cfg_ready,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  kernel_busy,
    output logic                  flush_kernel,
    output logic [7:0]            kernel_size,
    output logic [DATA_WIDTH-1:0] fltr_data,
    output logic                  fltr_valid,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  err_len,
    input  logic                  err_clr
);

    localparam int CW = $clog2(MAX_KERNEL) + 1;
    localparam int AW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
    localparam logic [7:0] MAX_SIZE = 8'(MAX_KERNEL);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_FREE,
        FLUSH,
        BURST,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         size_q;
    logic [CW-1:0]         wr_cnt;
    logic [CW-1:0]         rd_cnt;
    logic [DATA_WIDTH-1:0] buffer [MAX_KERNEL];

    logic beat_fire;
    logic cfg_ok;
    logic at_last_slot;
    logic burst_end;

    assign beat_fire    = s_valid && s_ready;
    assign cfg_ok       = (cfg_kernel_size != 8'd0) && (cfg_kernel_size <= MAX_SIZE);
    assign at_last_slot = (wr_cnt == size_q - CW'(1));
    assign burst_end    = (rd_cnt == size_q);

    // Weight storage carries no reset; it is always overwritten before being read.
    always_ff @(posedge clk) begin
        if (state == FILL && beat_fire) begin
            buffer[wr_cnt[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            size_q       <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            cfg_ready    <= 1'b0;
            s_ready      <= 1'b0;
            flush_kernel <= 1'b0;
            kernel_size  <= 8'd0;
            fltr_data    <= '0;
            fltr_valid   <= 1'b0;
            done         <= 1'b0;
            err_cfg      <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            flush_kernel <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        if (cfg_ok) begin
                            size_q    <= cfg_kernel_size[CW-1:0];
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                            cfg_ready <= 1'b0;
                            s_ready   <= 1'b1;
                            state     <= FILL;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (beat_fire) begin
                        if (at_last_slot) begin
                            // Size wins over s_last: a missing marker is flagged but the load proceeds.
                            wr_cnt  <= wr_cnt + CW'(1);
                            s_ready <= 1'b0;
                            state   <= WAIT_FREE;
                            if (!s_last) begin
                                err_len <= 1'b1;
                            end
                        end else if (s_last) begin
                            wr_cnt    <= '0;
                            err_len   <= 1'b1;
                            s_ready   <= 1'b0;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wr_cnt <= wr_cnt + CW'(1);
                        end
                    end
                end
                WAIT_FREE: begin
                    if (!kernel_busy) begin
                        flush_kernel <= 1'b1;
                        kernel_size  <= 8'(size_q);
                        state        <= FLUSH;
                    end
                end
                FLUSH: begin
                    fltr_valid <= 1'b1;
                    fltr_data  <= buffer[0];
                    rd_cnt     <= CW'(1);
                    state      <= BURST;
                end
                BURST: begin
                    // rd_cnt runs one word ahead of the word currently on fltr_data.
                    if (burst_end) begin
                        fltr_valid <= 1'b0;
                        fltr_data  <= '0;
                        state      <= DRAIN;
                    end else begin
                        fltr_data <= buffer[rd_cnt[AW-1:0]];
                        rd_cnt    <= rd_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!kernel_busy) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    fltr_valid <= 1'b0;
                    fltr_data  <= '0;
                    s_ready    <= 1'b0;
                    cfg_ready  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            if (err_clr) begin
                err_cfg <= 1'b0;
                err_len <= 1'b0;
            end
        end
    end

endmodule
